muldiv_iter: RTL and testbench
==============================

Name: muldiv_iter

Overview:
- Iterative multicycle multiply/divide unit implementing the RISC-V M-extension operations for the multicycle core.
- Replaces single-cycle combinational a*b, a/b and a%b in the ALU. Adds high-half multiplies, unsigned variants, spec-defined divide-by-zero and overflow results, and a start/done handshake.
- Sits beside the ALU. The controller FSM stalls in an execute state until done.

Parameters:
WIDTH, 32, operand/result width; must be >= 8.
UNROLL, 1, quotient/product bits retired per CALC cycle; must be 1, 2, 4 or 8; WIDTH % UNROLL == 0.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled on clk rising edge
kill  input  1  synchronous abort of current operation
funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a  input  WIDTH  rs1 operand (multiplicand/dividend)
b  input  WIDTH  rs2 operand (multiplier/divisor)
busy  output  1  high in PREP, CALC, FIX
done  output  1  one-cycle pulse, high in DONE
result  output  WIDTH  registered result

Behaviour:
- Reset (async, active-high):
  - state=IDLE; busy=0, done=0, result=0; internal registers and counter cleared.
  - Applies immediately, including mid-operation; no done is produced for the aborted op.
- Definitions: N = WIDTH/UNROLL.
- States: IDLE, PREP, CALC, FIX, DONE.
- Accept:
  - start=1 and kill=0 in IDLE or DONE: latch a, b, funct3 and go to PREP.
  - start while busy is ignored.
  - Operand changes after acceptance have no effect.
- PREP (1 cycle):
  - Record signs. MUL/MULH/DIV/REM: both operands signed. MULHSU: a signed, b unsigned. MULHU/DIVU/REMU: unsigned.
  - Form magnitudes; load counter = N; flag div_zero (b==0) and div_ovf (signed, a==min, b==all-ones).
- CALC (exactly N cycles, for all ops including special cases):
  - Multiply: shift-add over a 2*WIDTH accumulator, UNROLL multiplier bits per cycle.
  - Divide: restoring division on magnitudes, UNROLL quotient bits per cycle.
  - Counter decrements each cycle; at 1, go to FIX.
- FIX (1 cycle): sign correction and special-case override.
  - Product sign = sa^sb.
  - MUL returns low WIDTH bits; MULH/MULHSU/MULHU return high WIDTH bits.
  - Quotient sign = sa^sb; remainder sign = sa.
  - div_zero: DIV/DIVU quotient = all ones; REM/REMU = a.
  - div_ovf: DIV = a (min value); REM = 0.
  - result register written on the FIX->DONE edge.
- DONE (1 cycle): done=1, busy=0.
  - start=1 here begins the next op (back-to-back, PREP next cycle); otherwise go to IDLE.
- Latency: start sampled high in cycle t gives done=1 in cycle t+N+3. busy is high for N+2 cycles. Fixed regardless of operands/op (35 cycles for WIDTH=32, UNROLL=1).
- result holds its value until the next FIX->DONE write; it is not cleared by start or kill.
- kill=1 in any state: go to IDLE on the next edge; busy=0, no done.
  - kill and start in the same cycle: kill wins, start is dropped.
  - kill in IDLE: no effect.
- Unsigned arithmetic is modulo 2^WIDTH (products modulo 2^(2*WIDTH)); no overflow flags are output.

Test Plan:
1. WIDTH=32, UNROLL=1; MUL a=7, b=0xFFFFFFFD (-3), start in cycle 0 -> busy cycles 1..34, done=1 in cycle 35 only, result=0xFFFFFFEB held afterwards.
2. High-half multiplies -> MULH 0x80000000*0x80000000 = 0x40000000; MULHU same operands = 0x40000000; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF = 0xFFFFFFFF; MULHU 0xFFFFFFFF*0xFFFFFFFF = 0xFFFFFFFE.
3. Division -> DIV 0xFFFFFFF9/2 = 0xFFFFFFFD; REM 0xFFFFFFF9%2 = 0xFFFFFFFF; DIVU 7/2 = 3; REMU 0xFFFFFFF9%2 = 1.
4. Special cases -> DIV 5/0 = 0xFFFFFFFF; REMU 5/0 = 5; DIV 0x80000000/0xFFFFFFFF = 0x80000000; REM same operands = 0. All still take 35 cycles.
5. Handshake:
   - start pulsed at cycle 10 of a busy op -> ignored, single done at 35.
   - start held during DONE -> second done at cycle 70.
   - kill at cycle 20 -> IDLE at 21, no done, result unchanged.
   - kill and start together in IDLE -> stays IDLE.
6. Reset and unroll:
   - reset raised mid-CALC (between edges) -> busy/done/result = 0 immediately; after release, a fresh op completes normally.
   - UNROLL=4 instance, MUL 1234*5678 -> result = 7006652 (0x006AE9BC), done at cycle 11.

Source files
------------

// File: rtl/muldiv_iter.sv
// Iterative RISC-V M-extension multiply/divide unit with a start/done handshake.
// Fixed latency: PREP + N CALC cycles + FIX + DONE, where N = WIDTH/UNROLL.
module muldiv_iter #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             kill,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned N  = WIDTH / UNROLL;
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned W2 = 2 * WIDTH;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_CALC = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]       r_state, w_next_state;
  logic [WIDTH-1:0] r_a, r_b, r_mag, r_hi, r_lo, r_result;
  logic [2:0]       r_op;
  logic             r_sa, r_sb, r_div_zero, r_div_ovf, r_busy, r_done;
  logic [CW-1:0]    r_cnt;

  logic             w_accept, w_is_div, w_a_signed, w_b_signed, w_sa, w_sb;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_hi, w_lo, w_quo, w_rem, w_fix;
  logic [WIDTH:0]   w_sum, w_tmp;
  logic [W2-1:0]    w_prod, w_prod_s;

  assign w_accept = start && !kill && (r_state == S_IDLE || r_state == S_DONE);

  // Next-state logic; kill overrides everything, including a same-cycle start.
  always_comb begin
    w_next_state = r_state;
    if (kill) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start) w_next_state = S_PREP;
        S_PREP:  w_next_state = S_CALC;
        S_CALC:  if (r_cnt == CW'(1)) w_next_state = S_FIX;
        S_FIX:   w_next_state = S_DONE;
        S_DONE:  w_next_state = start ? S_PREP : S_IDLE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state == S_PREP) || (w_next_state == S_CALC) ||
                 (w_next_state == S_FIX);
      r_done  <= (w_next_state == S_DONE);
    end
  end

  // Operand signedness and magnitudes, evaluated in PREP from the latched operands.
  always_comb begin
    w_is_div   = r_op[2];
    w_a_signed = (r_op == 3'b000) || (r_op == 3'b001) || (r_op == 3'b010) ||
                 (r_op == 3'b100) || (r_op == 3'b110);
    w_b_signed = (r_op == 3'b000) || (r_op == 3'b001) ||
                 (r_op == 3'b100) || (r_op == 3'b110);
    w_sa       = w_a_signed && r_a[WIDTH-1];
    w_sb       = w_b_signed && r_b[WIDTH-1];
    w_a_mag    = w_sa ? (~r_a + WIDTH'(1)) : r_a;
    w_b_mag    = w_sb ? (~r_b + WIDTH'(1)) : r_b;
  end

  // UNROLL shift-add (multiply) or restoring-division steps per CALC cycle.
  always_comb begin
    w_hi  = r_hi;
    w_lo  = r_lo;
    w_sum = '0;
    w_tmp = '0;
    for (int i = 0; i < int'(UNROLL); i++) begin
      if (r_op[2]) begin
        w_tmp = {w_hi, w_lo[WIDTH-1]};
        w_lo  = {w_lo[WIDTH-2:0], 1'b0};
        if (w_tmp >= {1'b0, r_mag}) begin
          w_tmp = w_tmp - {1'b0, r_mag};
          w_lo  = {w_lo[WIDTH-1:1], 1'b1};
        end
        w_hi = w_tmp[WIDTH-1:0];
      end else begin
        w_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_mag} : '0);
        w_lo  = {w_sum[0], w_lo[WIDTH-1:1]};
        w_hi  = w_sum[WIDTH:1];
      end
    end
  end

  // Sign correction and divide special cases applied in FIX.
  always_comb begin
    w_prod   = {r_hi, r_lo};
    w_prod_s = (r_sa ^ r_sb) ? (~w_prod + W2'(1)) : w_prod;
    w_quo    = (r_sa ^ r_sb) ? (~r_lo + WIDTH'(1)) : r_lo;
    w_rem    = r_sa ? (~r_hi + WIDTH'(1)) : r_hi;
    case (r_op)
      3'b000:                 w_fix = w_prod_s[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: w_fix = w_prod_s[W2-1:WIDTH];
      3'b100, 3'b101:         w_fix = r_div_zero ? '1 : (r_div_ovf ? r_a : w_quo);
      default:                w_fix = r_div_zero ? r_a : (r_div_ovf ? '0 : w_rem);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= '0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
      r_div_zero <= 1'b0;
      r_div_ovf  <= 1'b0;
      r_mag      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_cnt      <= '0;
      r_result   <= '0;
    end else begin
      if (w_accept) begin
        r_a  <= a;
        r_b  <= b;
        r_op <= funct3;
      end
      if (!kill) begin
        case (r_state)
          S_PREP: begin
            r_sa       <= w_sa;
            r_sb       <= w_sb;
            r_div_zero <= (r_b == '0);
            r_div_ovf  <= w_is_div && !r_op[0] &&
                          (r_a == {1'b1, {(WIDTH-1){1'b0}}}) && (r_b == '1);
            r_mag      <= w_is_div ? w_b_mag : w_a_mag;
            r_lo       <= w_is_div ? w_a_mag : w_b_mag;
            r_hi       <= '0;
            r_cnt      <= CW'(N);
          end
          S_CALC: begin
            r_hi  <= w_hi;
            r_lo  <= w_lo;
            r_cnt <= r_cnt - CW'(1);
          end
          S_FIX:   r_result <= w_fix;
          default: ;
        endcase
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter: UNROLL=1 and UNROLL=4 instances, timing and result checks.
module tb_muldiv_iter;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start, kill, start4, kill4;
  logic [2:0]   funct3, funct3_4;
  logic [W-1:0] a, b, a4, b4;
  logic         busy, done, busy4, done4;
  logic [W-1:0] result, result4;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] q1[$];
  logic [W-1:0] q4[$];
  logic [W-1:0] last_res;

  always #5 clk = ~clk;

  muldiv_iter #(.WIDTH(32), .UNROLL(1)) u_dut (
    .clk(clk), .reset(reset), .start(start), .kill(kill), .funct3(funct3),
    .a(a), .b(b), .busy(busy), .done(done), .result(result)
  );

  muldiv_iter #(.WIDTH(32), .UNROLL(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .kill(kill4), .funct3(funct3_4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .result(result4)
  );

  // Scoreboard: every done pops the oldest expected result.
  always @(negedge clk) begin
    logic [W-1:0] exp1, exp4;
    if (done === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done: done=1 with no pending op at %0t", $time);
      end else begin
        exp1 = q1.pop_front();
        if (result !== exp1) begin
          errors++;
          $display("FAIL sb_result: got %h expected %h at %0t", result, exp1, $time);
        end
      end
    end
    if (done4 === 1'b1) begin
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL sb4_unexpected_done: done=1 with no pending op at %0t", $time);
      end else begin
        exp4 = q4.pop_front();
        if (result4 !== exp4) begin
          errors++;
          $display("FAIL sb4_result: got %h expected %h at %0t", result4, exp4, $time);
        end
      end
    end
  end

  // Drive an op with start high for cycle 0; optionally queue its expected result.
  task automatic launch(input logic [2:0] op, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic [W-1:0] exp, input bit push);
    @(negedge clk);
    funct3 = op;
    a      = aa;
    b      = bb;
    start  = 1'b1;
    kill   = 1'b0;
    if (push) begin
      q1.push_back(exp);
      last_res = exp;
    end
  endtask

  // Step n cycles recording busy/done; operands are scrambled unless a new start is scheduled.
  task automatic observe(input int n, input int start_at, input int kill_at,
                         input logic [2:0] nop, input logic [W-1:0] na, input logic [W-1:0] nb,
                         input logic [W-1:0] nexp, input bit npush,
                         output int busy_cnt, output int done_cnt,
                         output int first_done, output int last_done);
    busy_cnt = 0; done_cnt = 0; first_done = -1; last_done = -1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        if (first_done < 0) first_done = k;
        last_done = k;
      end
      start = (k == start_at);
      kill  = (k == kill_at);
      if (k == start_at) begin
        funct3 = nop; a = na; b = nb;
        if (npush) begin
          q1.push_back(nexp);
          last_res = nexp;
        end
      end else begin
        funct3 = 3'($urandom);
        a      = W'($urandom);
        b      = W'($urandom);
      end
    end
    start = 1'b0;
    kill  = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL reset_u1: busy=%b done=%b result=%h expected 0 0 0", busy, done, result);
    end
    checks++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || result4 !== '0) begin
      errors++;
      $display("FAIL reset_u4: busy=%b done=%b result=%h expected 0 0 0", busy4, done4, result4);
    end
    reset    = 1'b0;
    last_res = '0;
  endtask

  task automatic test_mul();
    int bc, dc, fd, ld;
    launch(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
    observe(40, -1, -1, 3'b000, '0, '0, '0, 1'b0, bc, dc, fd, ld);
    checks++;
    if (fd !== 35 || dc !== 1) begin
      errors++;
      $display("FAIL mul_done_timing: first_done=%0d count=%0d expected 35 1", fd, dc);
    end
    checks++;
    if (bc !== 34) begin
      errors++;
      $display("FAIL mul_busy_cycles: got %0d expected 34", bc);
    end
    checks++;
    if (result !== 32'hFFFF_FFEB) begin
      errors++;
      $display("FAIL mul_result_held: got %h expected ffffffeb", result);
    end
  endtask

  task automatic test_high_half();
    logic [2:0]   ops[4] = '{3'b001, 3'b011, 3'b010, 3'b011};
    logic [W-1:0] as[4]  = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [W-1:0] bs[4]  = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [W-1:0] es[4]  = '{32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    int bc, dc, fd, ld;
    for (int i = 0; i < 4; i++) begin
      launch(ops[i], as[i], bs[i], es[i], 1'b1);
      observe(36, -1, -1, 3'b000, '0, '0, '0, 1'b0, bc, dc, fd, ld);
      checks++;
      if (fd !== 35 || dc !== 1) begin
        errors++;
        $display("FAIL mulh_timing[%0d]: first_done=%0d count=%0d expected 35 1", i, fd, dc);
      end
    end
  endtask

  task automatic test_divide();
    logic [2:0]   ops[4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [W-1:0] as[4]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9};
    logic [W-1:0] bs[4]  = '{32'd2, 32'd2, 32'd2, 32'd2};
    logic [W-1:0] es[4]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd3, 32'd1};
    int bc, dc, fd, ld;
    for (int i = 0; i < 4; i++) begin
      launch(ops[i], as[i], bs[i], es[i], 1'b1);
      observe(36, -1, -1, 3'b000, '0, '0, '0, 1'b0, bc, dc, fd, ld);
      checks++;
      if (fd !== 35 || bc !== 34) begin
        errors++;
        $display("FAIL div_timing[%0d]: first_done=%0d busy=%0d expected 35 34", i, fd, bc);
      end
    end
  endtask

  task automatic test_special();
    logic [2:0]   ops[4] = '{3'b100, 3'b111, 3'b100, 3'b110};
    logic [W-1:0] as[4]  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [W-1:0] bs[4]  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [W-1:0] es[4]  = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int bc, dc, fd, ld;
    for (int i = 0; i < 4; i++) begin
      launch(ops[i], as[i], bs[i], es[i], 1'b1);
      observe(36, -1, -1, 3'b000, '0, '0, '0, 1'b0, bc, dc, fd, ld);
      checks++;
      if (fd !== 35 || dc !== 1) begin
        errors++;
        $display("FAIL special_timing[%0d]: first_done=%0d count=%0d expected 35 1", i, fd, dc);
      end
    end
  endtask

  task automatic test_start_ignored();
    int bc, dc, fd, ld;
    launch(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
    observe(45, 10, -1, 3'b000, 32'd9, 32'd9, '0, 1'b0, bc, dc, fd, ld);
    checks++;
    if (dc !== 1 || fd !== 35) begin
      errors++;
      $display("FAIL start_while_busy: done_count=%0d first_done=%0d expected 1 35", dc, fd);
    end
  endtask

  task automatic test_back_to_back();
    int bc, dc, fd, ld;
    launch(3'b101, 32'd100, 32'd7, 32'd14, 1'b1);
    observe(75, 35, -1, 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1, bc, dc, fd, ld);
    checks++;
    if (dc !== 2 || fd !== 35 || ld !== 70) begin
      errors++;
      $display("FAIL back_to_back: count=%0d first=%0d last=%0d expected 2 35 70", dc, fd, ld);
    end
    checks++;
    if (bc !== 68) begin
      errors++;
      $display("FAIL back_to_back_busy: got %0d expected 68", bc);
    end
  endtask

  task automatic test_kill();
    int bc, dc, fd, ld;
    launch(3'b000, 32'd3, 32'd5, 32'd15, 1'b0);
    observe(40, -1, 20, 3'b000, '0, '0, '0, 1'b0, bc, dc, fd, ld);
    checks++;
    if (dc !== 0 || bc !== 20) begin
      errors++;
      $display("FAIL kill_abort: done_count=%0d busy=%0d expected 0 20", dc, bc);
    end
    checks++;
    if (result !== last_res) begin
      errors++;
      $display("FAIL kill_result_kept: got %h expected %h", result, last_res);
    end
  endtask

  task automatic test_kill_start_idle();
    int bc, dc, fd, ld;
    @(negedge clk);
    funct3 = 3'b000; a = 32'd2; b = 32'd2; start = 1'b1; kill = 1'b1;
    observe(5, -1, -1, 3'b000, '0, '0, '0, 1'b0, bc, dc, fd, ld);
    checks++;
    if (bc !== 0 || dc !== 0 || result !== last_res) begin
      errors++;
      $display("FAIL kill_start_idle: busy=%0d done=%0d result=%h expected 0 0 %h",
               bc, dc, result, last_res);
    end
  endtask

  task automatic test_async_reset();
    int bc, dc, fd, ld;
    launch(3'b000, 32'h0001_2345, 32'h0000_0678, '0, 1'b0);
    observe(15, -1, -1, 3'b000, '0, '0, '0, 1'b0, bc, dc, fd, ld);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b result=%h expected 0 0 0", busy, done, result);
    end
    last_res = '0;
    @(negedge clk);
    reset = 1'b0;
    launch(3'b101, 32'd100, 32'd7, 32'd14, 1'b1);
    observe(40, -1, -1, 3'b000, '0, '0, '0, 1'b0, bc, dc, fd, ld);
    checks++;
    if (dc !== 1 || fd !== 35 || result !== 32'd14) begin
      errors++;
      $display("FAIL after_reset_op: count=%0d first=%0d result=%h expected 1 35 0000000e",
               dc, fd, result);
    end
  endtask

  task automatic test_unroll4();
    int bc = 0, dc = 0, fd = -1;
    @(negedge clk);
    funct3_4 = 3'b000; a4 = 32'd1234; b4 = 32'd5678; start4 = 1'b1;
    q4.push_back(32'd7006652);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (busy4 === 1'b1) bc++;
      if (done4 === 1'b1) begin
        dc++;
        if (fd < 0) fd = k;
      end
      start4 = 1'b0;
      a4 = W'($urandom);
      b4 = W'($urandom);
    end
    checks++;
    if (fd !== 11 || dc !== 1 || bc !== 10) begin
      errors++;
      $display("FAIL unroll4_timing: first_done=%0d count=%0d busy=%0d expected 11 1 10", fd, dc, bc);
    end
    checks++;
    if (result4 !== 32'h006A_E9BC) begin
      errors++;
      $display("FAIL unroll4_result: got %h expected 006ae9bc", result4);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    start = 1'b0; kill = 1'b0; funct3 = '0; a = '0; b = '0;
    start4 = 1'b0; kill4 = 1'b0; funct3_4 = '0; a4 = '0; b4 = '0;
    last_res = '0;
    test_reset();
    test_mul();
    test_high_half();
    test_divide();
    test_special();
    test_start_ignored();
    test_back_to_back();
    test_kill();
    test_kill_start_idle();
    test_async_reset();
    test_unroll4();
    repeat (3) @(negedge clk);
    checks++;
    if (q1.size() != 0 || q4.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: pending u1=%0d u4=%0d expected 0 0", q1.size(), q4.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
